bus_irq_timer: RTL and testbench
================================

Name: bus_irq_timer

Overview:
- Memory-mapped interval timer that acts as a responder on the 6502 CPU bus and drives the CPU's IRQ and NMI inputs.
- Decodes an 8-byte window of CPU address space and returns registered read data with the same one-cycle latency as block memory.
- The top level muxes its read data onto the CPU data input when the block flags a hit.
- Honours the CPU RDY stall: no bus side effects occur while rdy is low.

Parameters:
- BASE_ADDR, 16'hFE00: window base. Decode is addr[15:3] == BASE_ADDR[15:3]; BASE_ADDR[2:0] must be 0.
- PRESCALE_RST, 8'd0: reset value of the PRESCALE register.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous assert, active-high; all state returns to reset values
- addr  input  16  CPU address bus
- wdata  input  8  CPU write data
- we  input  1  CPU write enable
- rdy  input  1  CPU ready; bus access is qualified by rdy
- rdata  output  8  registered read data
- hit  output  1  registered: rdata is valid for the access presented last qualified cycle
- irq  output  1  level interrupt request to CPU, active-high
- nmi  output  1  non-maskable request to CPU, active-high level; CPU edge-detects it

Behaviour:
- Access: sel = window decode of addr. A write occurs when rdy & we & sel. A read is captured when rdy & ~we & sel.
- Read latency: on a clock edge with rdy=1, rdata <= reg[addr[2:0]] (or 8'h00 if not sel) and hit <= sel & ~we. With rdy=0, rdata and hit hold their values.
- Reset values: rdata=0, hit=0, irq=0, nmi=0, CTRL=0, STATUS=0, RELOAD=16'hFFFF, COUNT=16'hFFFF, PRESCALE=PRESCALE_RST, prescaler counter=0.
- Register map (offset):
  - 0 CTRL: bit0 EN, bit1 IE, bit2 AUTO (autoreload), bit3 NMIMODE; bits[7:4] read 0.
  - 1 STATUS: bit0 EXP. Write 1 to clear; reads have no side effect.
  - 2 RELOAD_LO, 3 RELOAD_HI.
  - 4 COUNT_LO, 5 COUNT_HI: read-only; writes are ignored.
  - 6 PRESCALE.
  - 7 reserved: reads 0, writes ignored.
- Start: a CTRL write that takes EN from 0 to 1 loads COUNT <= RELOAD and clears the prescaler in the same edge. Writing EN=1 while EN is already 1 does not reload.
- Tick: while EN=1, the prescaler counts 0..PRESCALE; tick is asserted when prescaler == PRESCALE, after which the prescaler wraps to 0.
- On tick:
  - If COUNT != 0: COUNT <= COUNT-1.
  - If COUNT == 0: EXP <= 1 (expire). If AUTO=1, COUNT <= RELOAD; else EN <= 0 and COUNT stays 0.
- Period: (RELOAD+1)*(PRESCALE+1) clocks from the start edge to the EXP set edge.
- RELOAD writes mid-count affect only the next reload. PRESCALE writes take effect at the next prescaler compare.
- Outputs, registered one cycle after EXP/CTRL change:
  - irq = EXP & IE & ~NMIMODE
  - nmi = EXP & IE & NMIMODE
- Simultaneous expire and STATUS clear-write in the same cycle: expire wins, EXP stays 1.
- Simultaneous CTRL write clearing EN and a tick: the write wins, no expire.
- Stall: rdy=0 does not stop the timer; it only blocks bus reads and writes.
- Async rst mid-count returns all state to reset values immediately. The first edge after release behaves as idle.

Optional Feature:
- Macro: BUS_IRQ_TIMER_SNAPSHOT_EN.
- Defined: a read of COUNT_LO also latches COUNT[15:8] into a shadow register in the same edge. COUNT_HI reads return the shadow, so a LO-then-HI read pair is atomic. Shadow reset value is 8'hFF.
- Undefined: COUNT_HI returns live COUNT[15:8]; no shadow register exists.

Test Plan:
- Reset, then read offsets 0..7 -> rdata 00,00,FF,FF,FF,FF,PRESCALE_RST,00 with hit=1 one cycle after each address; address 16'h0200 -> hit=0.
- RELOAD=0x0003, PRESCALE=1, CTRL=0x03 -> EXP=1 exactly 8 clocks after the CTRL write edge, irq=1 the following cycle, EN reads 0, COUNT=0.
- AUTO: RELOAD=0x0002, PRESCALE=0, CTRL=0x07 -> EXP set every 3 clocks. Write STATUS=0x01 on an expire cycle -> EXP stays 1. Write on a non-expire cycle -> EXP=0, irq drops next cycle.
- NMIMODE: CTRL=0x0B with RELOAD=0 -> nmi rises, irq stays 0. Clearing EXP drops nmi; the next expiry produces a new rising edge.
- Hold rdy=0 during a write to RELOAD_LO and a read of CTRL -> RELOAD unchanged, rdata/hit held, timer keeps counting.
- With BUS_IRQ_TIMER_SNAPSHOT_EN defined: COUNT=0x0100 and PRESCALE=0; read COUNT_LO (0x00), then COUNT_HI after a decrement -> 0x01, not the live 0x00.

Source files
------------

// File: rtl/bus_irq_timer_if.sv
// CPU-side bus bundle for the interval timer: address/data/strobes in, registered read data out.
// Handshake: an access is taken only on a clock edge where rdy=1; with rdy=0 the responder ignores the bus and holds rdata/hit.
interface bus_irq_timer_if;
   logic [15:0] addr;
   logic [7:0]  wdata;
   logic        we;
   logic        rdy;
   logic [7:0]  rdata;
   logic        hit;

   modport master (output addr, output wdata, output we, output rdy,
                   input rdata, input hit);
   modport slave  (input addr, input wdata, input we, input rdy,
                   output rdata, output hit);
endinterface

// File: rtl/bus_irq_timer.sv
// Memory-mapped 16-bit interval timer with prescaler, driving CPU irq/nmi levels.
// Optional BUS_IRQ_TIMER_SNAPSHOT_EN: a COUNT_LO read latches COUNT_HI into a shadow for atomic reads.
module bus_irq_timer #(
   parameter logic [15:0] BASE_ADDR    = 16'hFE00,
   parameter logic [7:0]  PRESCALE_RST = 8'd0
) (
   input  logic             clk,
   input  logic             rst,
   bus_irq_timer_if.slave   bus,
   output logic             irq,
   output logic             nmi
);

   localparam logic [2:0] OFF_CTRL     = 3'd0;
   localparam logic [2:0] OFF_STATUS   = 3'd1;
   localparam logic [2:0] OFF_RELOAD_L = 3'd2;
   localparam logic [2:0] OFF_RELOAD_H = 3'd3;
   localparam logic [2:0] OFF_COUNT_L  = 3'd4;
   localparam logic [2:0] OFF_COUNT_H  = 3'd5;
   localparam logic [2:0] OFF_PRESCALE = 3'd6;

   logic [3:0]  ctrl;       // {NMIMODE, AUTO, IE, EN}
   logic        exp_flag;
   logic [15:0] reload;
   logic [15:0] count;
   logic [7:0]  prescale;
   logic [7:0]  pre_cnt;

   logic        sel, wr;
   logic [2:0]  off;
   logic        wr_ctrl, start, stop_wr, tick, tick_ok, expire;
   logic [3:0]  ctrl_next;
   logic [15:0] count_next;
   logic [7:0]  pre_next;
   logic [7:0]  rd_mux;
   logic [7:0]  count_hi_view;

   assign sel = (bus.addr[15:3] == BASE_ADDR[15:3]);
   assign off = bus.addr[2:0];
   assign wr  = bus.rdy & bus.we & sel;

   assign wr_ctrl = wr & (off == OFF_CTRL);
   assign start   = wr_ctrl & bus.wdata[0] & ~ctrl[0];
   assign stop_wr = wr_ctrl & ~bus.wdata[0];
   assign tick    = ctrl[0] & (pre_cnt == prescale);
   // A CTRL write that clears EN beats a coincident tick entirely.
   assign tick_ok = tick & ~stop_wr;
   assign expire  = tick_ok & (count == 16'd0);

`ifdef BUS_IRQ_TIMER_SNAPSHOT_EN
   logic [7:0] shadow;
   logic       rd;
   assign rd = bus.rdy & ~bus.we & sel;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow <= 8'hFF;
      end else if (rd && (off == OFF_COUNT_L)) begin
         shadow <= count[15:8];
      end
   end
   assign count_hi_view = shadow;
`else
   assign count_hi_view = count[15:8];
`endif

   always_comb begin
      ctrl_next = ctrl;
      if (wr_ctrl) ctrl_next = bus.wdata[3:0];
      if (expire && !ctrl[2]) ctrl_next[0] = 1'b0;
   end

   always_comb begin
      count_next = count;
      if (start) begin
         count_next = reload;
      end else if (tick_ok) begin
         if (count != 16'd0)  count_next = count - 16'd1;
         else if (ctrl[2])    count_next = reload;
      end
   end

   always_comb begin
      pre_next = pre_cnt;
      if (start)        pre_next = 8'd0;
      else if (ctrl[0]) pre_next = tick ? 8'd0 : pre_cnt + 8'd1;
   end

   always_comb begin
      rd_mux = 8'h00;
      case (off)
         OFF_CTRL:     rd_mux = {4'h0, ctrl};
         OFF_STATUS:   rd_mux = {7'h00, exp_flag};
         OFF_RELOAD_L: rd_mux = reload[7:0];
         OFF_RELOAD_H: rd_mux = reload[15:8];
         OFF_COUNT_L:  rd_mux = count[7:0];
         OFF_COUNT_H:  rd_mux = count_hi_view;
         OFF_PRESCALE: rd_mux = prescale;
         default:      rd_mux = 8'h00;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl      <= 4'h0;
         exp_flag  <= 1'b0;
         reload    <= 16'hFFFF;
         count     <= 16'hFFFF;
         prescale  <= PRESCALE_RST;
         pre_cnt   <= 8'd0;
         bus.rdata <= 8'h00;
         bus.hit   <= 1'b0;
         irq       <= 1'b0;
         nmi       <= 1'b0;
      end else begin
         ctrl    <= ctrl_next;
         count   <= count_next;
         pre_cnt <= pre_next;

         // Expire wins over a same-cycle write-1-to-clear.
         if (expire)
            exp_flag <= 1'b1;
         else if (wr && (off == OFF_STATUS) && bus.wdata[0])
            exp_flag <= 1'b0;

         if (wr && (off == OFF_RELOAD_L)) reload[7:0]  <= bus.wdata;
         if (wr && (off == OFF_RELOAD_H)) reload[15:8] <= bus.wdata;
         if (wr && (off == OFF_PRESCALE)) prescale     <= bus.wdata;

         if (bus.rdy) begin
            bus.rdata <= sel ? rd_mux : 8'h00;
            bus.hit   <= sel & ~bus.we;
         end

         irq <= exp_flag & ctrl[1] & ~ctrl[3];
         nmi <= exp_flag & ctrl[1] &  ctrl[3];
      end
   end

endmodule

// File: tb/tb_bus_irq_timer.sv
// Bench for bus_irq_timer: reset-state table, directed timer corner cases, randomized bus
// traffic against a register-map model, and randomized periods against the closed-form period.
module tb_bus_irq_timer;

   localparam logic [15:0] BASE         = 16'hFE00;
   localparam logic [7:0]  PRESCALE_RST = 8'd0;

   logic clk;
   logic rst;
   logic irq, nmi;

   bus_irq_timer_if bus ();

   bus_irq_timer #(.BASE_ADDR(BASE), .PRESCALE_RST(PRESCALE_RST)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus),
      .irq (irq),
      .nmi (nmi)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   int n_checks = 0;
   int n_fail   = 0;

   // register-map model for the randomized bus phase (timer disabled there)
   logic [3:0]  m_ctrl;
   logic [15:0] m_reload;
   logic [7:0]  m_prescale;
   logic [7:0]  m_rdata;
   logic        m_hit;

   typedef struct {
      logic [15:0] addr;
      logic        we;
      logic [7:0]  wdata;
      logic        rdy;
      logic [7:0]  exp_rdata;
      logic        exp_hit;
   } vec_t;

   vec_t       vecs[9];
   logic [7:0] rst_vals[8];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // driver tasks
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      bus.addr  = 16'h0000;
      bus.we    = 1'b0;
      bus.wdata = 8'h00;
      bus.rdy   = 1'b1;
   endtask

   task automatic wr(input logic [2:0] o, input logic [7:0] d);
      bus.addr  = BASE | 16'(o);
      bus.we    = 1'b1;
      bus.wdata = d;
      bus.rdy   = 1'b1;
      cyc();
      idle_bus();
   endtask

   task automatic rd_chk(input logic [2:0] o, input logic [7:0] exp, input string name);
      bus.addr = BASE | 16'(o);
      bus.we   = 1'b0;
      bus.rdy  = 1'b1;
      cyc();
      check(name, 16'(bus.rdata), 16'(exp));
      check({name, "_hit"}, 16'(bus.hit), 16'd1);
      idle_bus();
   endtask

   function automatic logic [7:0] mreg(input logic [2:0] o);
      case (o)
         3'd0:    return {4'h0, m_ctrl};
         3'd2:    return m_reload[7:0];
         3'd3:    return m_reload[15:8];
         3'd4:    return 8'hFF;
         3'd5:    return 8'hFF;
         3'd6:    return m_prescale;
         default: return 8'h00;
      endcase
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      idle_bus();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      logic [15:0] a;
      logic [2:0]  o;
      logic [7:0]  d;
      logic        wbit, rbit, inwin;
      int          r, p, nm, j, n, period;

      rst = 1'b1;
      idle_bus();
      #1;
      check("async_reset_irq", 16'(irq), 16'd0);
      do_reset();
      check("reset_rdata", 16'(bus.rdata), 16'd0);
      check("reset_hit",   16'(bus.hit),   16'd0);
      check("reset_nmi",   16'(nmi),       16'd0);

      // reset-value table
      rst_vals = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, PRESCALE_RST, 8'h00};
      for (int i = 0; i < 8; i++)
         vecs[i] = '{addr: BASE + 16'(i), we: 1'b0, wdata: 8'h00, rdy: 1'b1,
                     exp_rdata: rst_vals[i], exp_hit: 1'b1};
      vecs[8] = '{addr: 16'h0200, we: 1'b0, wdata: 8'h00, rdy: 1'b1,
                  exp_rdata: 8'h00, exp_hit: 1'b0};
      for (int i = 0; i < 9; i++) begin
         bus.addr  = vecs[i].addr;
         bus.we    = vecs[i].we;
         bus.wdata = vecs[i].wdata;
         bus.rdy   = vecs[i].rdy;
         cyc();
         check($sformatf("table%0d_rdata", i), 16'(bus.rdata), 16'(vecs[i].exp_rdata));
         check($sformatf("table%0d_hit", i),   16'(bus.hit),   16'(vecs[i].exp_hit));
      end
      idle_bus();

      // one-shot: RELOAD=3, PRESCALE=1 -> expire 8 clocks after the start edge
      wr(3'd2, 8'h03); wr(3'd3, 8'h00); wr(3'd6, 8'h01);
      wr(3'd0, 8'h03);
      repeat (7) cyc();
      rd_chk(3'd1, 8'h00, "oneshot_status_before");
      check("oneshot_irq_e8", 16'(irq), 16'd0);
      cyc();
      check("oneshot_irq_e9", 16'(irq), 16'd1);
      rd_chk(3'd1, 8'h01, "oneshot_status");
      rd_chk(3'd0, 8'h02, "oneshot_ctrl");
      rd_chk(3'd4, 8'h00, "oneshot_count_lo");
      rd_chk(3'd5, 8'h00, "oneshot_count_hi");
      wr(3'd1, 8'h01);
      cyc();
      check("oneshot_irq_cleared", 16'(irq), 16'd0);

      // autoreload, clear-vs-expire, and stop-vs-tick
      wr(3'd2, 8'h02); wr(3'd3, 8'h00); wr(3'd6, 8'h00);
      wr(3'd0, 8'h07);
      repeat (2) cyc();
      cyc(); check("auto_e3_irq", 16'(irq), 16'd0);
      cyc(); check("auto_e4_irq", 16'(irq), 16'd1);
      cyc();
      wr(3'd1, 8'h01);
      wr(3'd1, 8'h01);
      check("auto_clr_on_expire_irq", 16'(irq), 16'd1);
      cyc(); check("auto_e8_irq", 16'(irq), 16'd0);
      cyc(); check("auto_e9_irq", 16'(irq), 16'd0);
      cyc(); check("auto_e10_irq", 16'(irq), 16'd1);
      wr(3'd1, 8'h01);
      wr(3'd0, 8'h06);
      repeat (2) cyc();
      check("stop_vs_tick_irq", 16'(irq), 16'd0);
      rd_chk(3'd1, 8'h00, "stop_vs_tick_status");
      rd_chk(3'd4, 8'h00, "stop_vs_tick_count");
      wr(3'd0, 8'h00);

      // NMI mode with RELOAD=0
      wr(3'd2, 8'h00); wr(3'd3, 8'h00);
      wr(3'd0, 8'h0B);
      cyc(); check("nmi_e1", 16'(nmi), 16'd0);
      cyc(); check("nmi_rise", 16'(nmi), 16'd1);
      check("nmi_irq_low", 16'(irq), 16'd0);
      wr(3'd1, 8'h01);
      cyc(); check("nmi_drop", 16'(nmi), 16'd0);
      wr(3'd0, 8'h0B);
      cyc();
      cyc(); check("nmi_rise2", 16'(nmi), 16'd1);
      wr(3'd1, 8'h01); wr(3'd0, 8'h00);

      // rdy stall: no bus effect, timer keeps running
      wr(3'd2, 8'h05); wr(3'd3, 8'h00);
      wr(3'd0, 8'h01);
      rd_chk(3'd0, 8'h01, "stall_pre_ctrl");
      bus.addr = BASE | 16'd2; bus.we = 1'b1; bus.wdata = 8'hAA; bus.rdy = 1'b0;
      cyc();
      check("stall_wr_rdata", 16'(bus.rdata), 16'h01);
      check("stall_wr_hit",   16'(bus.hit),   16'd1);
      bus.addr = BASE; bus.we = 1'b0; bus.rdy = 1'b0;
      cyc();
      check("stall_rd_rdata", 16'(bus.rdata), 16'h01);
      idle_bus();
      rd_chk(3'd2, 8'h05, "stall_reload_kept");
      rd_chk(3'd4, 8'h01, "stall_count_running");
      wr(3'd0, 8'h00);

`ifdef BUS_IRQ_TIMER_SNAPSHOT_EN
      wr(3'd2, 8'h00); wr(3'd3, 8'h01); wr(3'd6, 8'h00);
      wr(3'd0, 8'h01);
      rd_chk(3'd4, 8'h00, "snap_lo");
      rd_chk(3'd5, 8'h01, "snap_hi_shadow");
      wr(3'd0, 8'h00);
`else
      wr(3'd2, 8'h00); wr(3'd3, 8'h01); wr(3'd6, 8'h00);
      wr(3'd0, 8'h01);
      rd_chk(3'd4, 8'h00, "live_lo");
      rd_chk(3'd5, 8'h00, "live_hi");
      wr(3'd0, 8'h00);
`endif

      // async reset mid-count
      wr(3'd2, 8'h20); wr(3'd3, 8'h00);
      wr(3'd0, 8'h03);
      rd_chk(3'd2, 8'h20, "arst_pre_read");
      #3;
      rst = 1'b1;
      #1;
      check("arst_rdata", 16'(bus.rdata), 16'd0);
      check("arst_hit",   16'(bus.hit),   16'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      rd_chk(3'd0, 8'h00, "arst_ctrl");
      rd_chk(3'd4, 8'hFF, "arst_count");
      rd_chk(3'd2, 8'hFF, "arst_reload");

      // randomized bus traffic against the register-map model
      do_reset();
      m_ctrl = 4'h0; m_reload = 16'hFFFF; m_prescale = PRESCALE_RST;
      m_rdata = 8'h00; m_hit = 1'b0;
      for (int k = 0; k < 60; k++) begin
         o     = 3'($urandom_range(0, 7));
         inwin = 1'($urandom_range(0, 1));
         wbit  = 1'($urandom_range(0, 1));
         rbit  = ($urandom_range(0, 3) != 0);
         d     = 8'($urandom);
         if (wbit && o == 3'd0) d = d & 8'h0E;
         a = 16'($urandom);
         if (a[15:3] == BASE[15:3]) a = a ^ 16'h0100;
         if (inwin) a = BASE | 16'(o);
         if (rbit) begin
            m_rdata = inwin ? mreg(o) : 8'h00;
            m_hit   = inwin & ~wbit;
         end
         bus.addr = a; bus.we = wbit; bus.wdata = d; bus.rdy = rbit;
         cyc();
         check($sformatf("rand_bus%0d_rdata", k), 16'(bus.rdata), 16'(m_rdata));
         check($sformatf("rand_bus%0d_hit", k),   16'(bus.hit),   16'(m_hit));
         if (rbit && wbit && inwin) begin
            case (o)
               3'd0: m_ctrl = d[3:0];
               3'd2: m_reload[7:0] = d;
               3'd3: m_reload[15:8] = d;
               3'd6: m_prescale = d;
               default: ;
            endcase
         end
      end
      idle_bus();
      check("rand_bus_irq", 16'(irq), 16'd0);

      // randomized periods: irq/nmi rises (RELOAD+1)*(PRESCALE+1)+1 clocks after start
      for (int k = 0; k < 6; k++) begin
         wr(3'd0, 8'h00); wr(3'd1, 8'h01);
         r  = $urandom_range(0, 15);
         p  = $urandom_range(0, 3);
         nm = $urandom_range(0, 1);
         period = (r + 1) * (p + 1);
         wr(3'd2, 8'(r)); wr(3'd3, 8'h00); wr(3'd6, 8'(p));
         wr(3'd0, 8'(8'h03 | (nm << 3)));
         j = $urandom_range(0, period - 1);
         repeat (j) cyc();
         rd_chk(3'd4, 8'(r - j / (p + 1)), $sformatf("rand_t%0d_count", k));
         n = j + 1;
         while (!(irq || nmi) && n < 5000) begin
            cyc();
            n++;
         end
         check($sformatf("rand_t%0d_latency", k), 16'(n), 16'(period + 1));
         check($sformatf("rand_t%0d_irq", k), 16'(irq), 16'(nm == 0));
         check($sformatf("rand_t%0d_nmi", k), 16'(nmi), 16'(nm == 1));
         rd_chk(3'd1, 8'h01, $sformatf("rand_t%0d_status", k));
         rd_chk(3'd0, 8'(8'h02 | (nm << 3)), $sformatf("rand_t%0d_ctrl", k));
         wr(3'd1, 8'h01);
         cyc();
         check($sformatf("rand_t%0d_clear", k), 16'(irq | nmi), 16'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
